// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame sequencer: qualifies bits with start-of-frame and strobe,
// assembles WIDTH-bit words into a valid/ready output register, flags overruns and aborts.
module sipo_frame_ctrl #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sof,
    input  logic             i_bit_valid,
    input  logic             i_serial,
    output logic [WIDTH-1:0] o_word,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_overrun,
    output logic             o_abort
);

    localparam int BC_W = $clog2(WIDTH + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WIDTH - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_shift;
    logic [BC_W-1:0]   r_bitcnt;
    logic [TO_W-1:0]   r_tocnt;
    logic [WIDTH-1:0]  r_word;
    logic              r_valid;
    logic              r_overrun;
    logic              r_abort;

    state_t            w_state_nxt;
    logic [WIDTH-1:0]  w_shift_nxt;
    logic [BC_W-1:0]   w_bitcnt_nxt;
    logic [TO_W-1:0]   w_tocnt_nxt;
    logic              w_complete;
    logic              w_abort_nxt;
    logic [WIDTH-1:0]  w_final_word;

    function automatic logic [WIDTH-1:0] f_insert(input logic [WIDTH-1:0] v, input logic b);
        if (MSB_FIRST)
            return {v[WIDTH-2:0], b};
        else
            return {b, v[WIDTH-1:1]};
    endfunction

    assign w_final_word = f_insert(r_shift, i_serial);

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_tocnt_nxt  = r_tocnt;
        w_complete   = 1'b0;
        w_abort_nxt  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_sof) begin
                    w_state_nxt = S_SHIFT;
                    w_tocnt_nxt = '0;
                    if (i_bit_valid) begin
                        w_shift_nxt  = f_insert('0, i_serial);
                        w_bitcnt_nxt = BC_W'(1);
                    end else begin
                        w_shift_nxt  = '0;
                        w_bitcnt_nxt = '0;
                    end
                end
            end
            S_SHIFT: begin
                // Completing the frame outranks a coincident restart.
                if (i_bit_valid && r_bitcnt == BC_LAST) begin
                    w_complete   = 1'b1;
                    w_state_nxt  = S_IDLE;
                    w_shift_nxt  = '0;
                    w_bitcnt_nxt = '0;
                    w_tocnt_nxt  = '0;
                end else if (i_sof) begin
                    w_abort_nxt = 1'b1;
                    w_tocnt_nxt = '0;
                    if (i_bit_valid) begin
                        w_shift_nxt  = f_insert('0, i_serial);
                        w_bitcnt_nxt = BC_W'(1);
                    end else begin
                        w_shift_nxt  = '0;
                        w_bitcnt_nxt = '0;
                    end
                end else if (i_bit_valid) begin
                    w_shift_nxt  = f_insert(r_shift, i_serial);
                    w_bitcnt_nxt = r_bitcnt + BC_W'(1);
                    w_tocnt_nxt  = '0;
                end else if (r_tocnt == TO_LAST) begin
                    w_abort_nxt  = 1'b1;
                    w_state_nxt  = S_IDLE;
                    w_shift_nxt  = '0;
                    w_bitcnt_nxt = '0;
                    w_tocnt_nxt  = '0;
                end else begin
                    w_tocnt_nxt = r_tocnt + TO_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_tocnt   <= '0;
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_tocnt   <= w_tocnt_nxt;
            r_abort   <= w_abort_nxt;
            r_overrun <= 1'b0;
            // A full output register only takes a new word if it is drained in the same cycle.
            if (w_complete) begin
                if (!r_valid || i_ready) begin
                    r_word  <= w_final_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_word    = r_word;
    assign o_valid   = r_valid;
    assign o_busy    = (r_state == S_SHIFT);
    assign o_overrun = r_overrun;
    assign o_abort   = r_abort;

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Sequences a serial-in/parallel-out capture path.
- Qualifies incoming serial bits with a start-of-frame pulse and a per-bit strobe, and counts exactly WIDTH bits.
- Assembles the word and presents it on a valid/ready output register.
- Sits between a serial line front-end (bit recovery) and word-oriented consumers. Also flags overruns, inter-bit timeouts and frame restarts.

Parameters:
- WIDTH, 8: bits per word. Must be 2 or more.
- MSB_FIRST, 1: 1 = first received bit lands in o_word[WIDTH-1]; 0 = first bit lands in o_word[0].
- TIMEOUT, 255: maximum clk cycles allowed between accepted bits inside a frame before abort. Must be 1 or more.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_sof  in  1  start-of-frame pulse, one cycle
- i_bit_valid  in  1  i_serial is valid this cycle
- i_serial  in  1  serial data bit
- o_word  out  WIDTH  assembled parallel word
- o_valid  out  1  o_word holds an unconsumed word
- i_ready  in  1  consumer accepts o_word this cycle when o_valid=1
- o_busy  out  1  a frame is in progress (state SHIFT)
- o_overrun  out  1  one-cycle pulse: a completed word was dropped
- o_abort  out  1  one-cycle pulse: a partial frame was discarded

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; shift register, bit counter and timeout counter cleared.
  - o_word=0, o_valid=0, o_busy=0, o_overrun=0, o_abort=0.
  - Reset overrides all other inputs, including mid-frame; the partial word is lost and no o_abort is raised.
- State machine, two states:
  - IDLE:
    - i_bit_valid without i_sof is ignored.
    - i_sof=1 -> SHIFT; bit counter and timeout counter cleared.
    - If i_bit_valid=1 in the same cycle as i_sof, that bit is accepted as bit 0 and the counter becomes 1.
  - SHIFT:
    - Each i_bit_valid=1 shifts i_serial in:
      - MSB_FIRST=1: shift left, new bit enters at LSB.
      - MSB_FIRST=0: shift right, new bit enters at MSB.
    - Each accepted bit increments the bit counter and clears the timeout counter.
    - On acceptance of bit WIDTH-1 (the WIDTH-th bit), the word completes and the state returns to IDLE.
    - A new i_sof is required for every word.
- Completion and output handshake:
  - o_word/o_valid update at the clk edge that accepts the final bit, so they are visible the cycle after the final bit is presented.
  - The word is loaded if o_valid=0, or if o_valid=1 and i_ready=1 in that cycle (simultaneous consume and load): o_valid stays 1, no overrun.
  - If o_valid=1 and i_ready=0, the new word is dropped, o_word keeps the old word, and o_overrun pulses for one cycle.
  - A transfer occurs on o_valid=1 and i_ready=1. With no new word loading, o_valid=0 next cycle and o_word retains its last value.
  - o_word is stable while o_valid=1 and i_ready=0.
- Restart: i_sof=1 while in SHIFT, with the frame not completing this cycle:
  - The partial frame is discarded, o_abort pulses, and the state stays SHIFT with counters cleared.
  - A coincident i_bit_valid bit becomes bit 0 of the new frame.
  - If the same cycle accepts the final bit of the current frame, completion wins: the word completes, there is no abort, and the i_sof is ignored.
- Timeout:
  - In SHIFT, the timeout counter increments on every cycle with i_bit_valid=0.
  - When it reaches TIMEOUT: o_abort pulses, state -> IDLE, partial word discarded.
  - i_sof in that same cycle takes priority as a restart (single o_abort pulse, state stays SHIFT).
- o_busy = (state==SHIFT), registered.
- Counter widths:
  - Bit counter: clog2(WIDTH+1) bits.
  - Timeout counter: clog2(TIMEOUT+1) bits.
  - Neither counter wraps.

Test Plan:
- Basic MSB-first: WIDTH=8, MSB_FIRST=1, i_ready=1; i_sof with bits 1,0,1,0,0,1,0,1 on consecutive cycles -> o_word=0xA5 and o_valid=1 one cycle after the last bit, o_valid=0 the cycle after; o_busy high for exactly the frame.
- LSB-first with gaps: MSB_FIRST=0, same bit sequence with 3 idle cycles between bits (TIMEOUT=255) -> o_word=0xA5 reversed = 0xA5 bit-swapped = 0xA5? Use sequence 1,1,0,0,0,0,0,0 instead -> o_word=0x03.
- Backpressure/overrun: i_ready=0; frame 0x3C then frame 0xFF -> o_word remains 0x3C, o_overrun one-cycle pulse at 0xFF completion. Then i_ready=1 -> one transfer of 0x3C, o_valid drops. Also: raise i_ready in the exact completion cycle of a second frame 0x81 -> no overrun, o_word=0x81, o_valid stays 1.
- Restart: i_sof, 4 bits, then i_sof with a bit in the same cycle, plus 7 more bits of 0x96 -> o_abort single pulse, o_word=0x96. Also: i_sof on the 8th bit -> word completes, no abort.
- Timeout: TIMEOUT=4; i_sof, 3 bits, 4 idle cycles -> o_abort pulse, o_busy=0, no o_valid. Subsequent stray i_bit_valid without i_sof is ignored.
- Reset mid-frame: rst after 5 bits while o_valid=1 -> all outputs 0 next cycle, no o_abort. A fresh frame 0x5A completes normally.
